mod_147_rx_align: RTL and testbench
===================================

Name: mod_147_rx_align

Overview:
- PCS receive symbol aligner for 10BASE-T1S (Clause 147). Sits directly upstream of the PCS receive state machine.
- Takes the serial DME-decoded bit stream and signal-detect from the PMA, and finds 5B symbol boundaries by locking onto SYNC (J) codes.
- Delivers RXn, the three-deep history RXn_1/RXn_2/RXn_3, and a one-clock RSCD strobe per received symbol.

Parameters:
- SYNC_CODE, 5'b11000: 5B code (J) used for alignment.
- LOCK_SYNC_COUNT, 2: consecutive aligned SYNC codes required to declare lock (range 1..7).

Ports:
- clk  input  1  PCS receive clock.
- pcs_reset  input  1  reset, asynchronous, active-high.
- rx_sd  input  1  PMA signal detect; low means line silent.
- rx_bit  input  1  received bit, sampled only when rx_bit_valid=1.
- rx_bit_valid  input  1  one-clock strobe per recovered bit.
- RSCD  output  1  one-clock pulse: new symbol on RXn; RXn_1..RXn_3 shifted.
- RXn  output  5  newest symbol.
- RXn_1  output  5  symbol before RXn.
- RXn_2  output  5  two symbols before RXn.
- RXn_3  output  5  three symbols before RXn.
- rx_locked  output  1  high while in LOCKED.
- align_state  output  2  NO_SIGNAL=0, HUNT=1, CONFIRM=2, LOCKED=3.

Behaviour:
- Clock and reset: one clock. pcs_reset is asynchronous, active-high.
- Reset values: RSCD=0, RXn..RXn_3=SILENCE (shared Clause 147 constant), rx_locked=0, align_state=NO_SIGNAL, window=0, phase=0, sync_cnt=0.
- Bit shifting: window <= {window[3:0], rx_bit} on each rx_bit_valid. The first bit of a symbol ends in bit 4.
- Phase counter: phase counts 0..4 on rx_bit_valid and wraps to 0. A symbol boundary is the rx_bit_valid on which phase=4.
- Emit:
  - At every boundary, the block emits one symbol.
  - RSCD=1 for the next clock only.
  - In the same cycle: RXn_3<=RXn_2, RXn_2<=RXn_1, RXn_1<=RXn, RXn<=emitted value.
- Emitted value: the window including the current bit when in LOCKED; SILENCE in every other state.
- Latency: RSCD and RXn update on the clock edge after the 5th bit's strobe is sampled.
- NO_SIGNAL:
  - phase free-runs, so SILENCE is emitted every 5 bit strobes.
  - rx_sd=1 -> HUNT. window is cleared.
- HUNT:
  - Checks on every bit strobe: if the updated window == SYNC_CODE, then phase:=0 (next bit starts a symbol) and sync_cnt:=1.
  - If LOCK_SYNC_COUNT=1, go to LOCKED; otherwise go to CONFIRM.
  - phase keeps running otherwise, and SILENCE emission continues.
- CONFIRM: at each boundary:
  - window==SYNC_CODE: sync_cnt++. Reaching LOCK_SYNC_COUNT -> LOCKED. The confirming SYNC itself is emitted as SILENCE.
  - Otherwise -> HUNT, sync_cnt:=0.
- LOCKED:
  - Emits window contents at each boundary.
  - The first emitted symbol is the one following the final confirming SYNC.
  - Stays in LOCKED until rx_sd drops; no realignment while locked.
- rx_sd=0 in any state except NO_SIGNAL -> NO_SIGNAL on the next clock; sync_cnt:=0, rx_locked:=0. Any partial symbol is discarded.
- Simultaneous rx_sd falling and rx_bit_valid: rx_sd wins and the bit is ignored. The boundary emit still occurs, with SILENCE.
- rx_bit_valid on consecutive clocks is legal. RSCD never lasts longer than one clock.
- pcs_reset mid-symbol: all state returns to reset values immediately. No RSCD pulse is issued during or on release of reset.

Optional Feature:
- Macro: RX_SYM_ERR_CNT_EN.
- When defined:
  - Adds output sym_err_cnt [7:0].
  - Counts emitted LOCKED symbols whose code is not one of: the 16 4B/5B data codes, 11000, 10001, 01101, 00111, 00100, 11111.
  - Saturates at 255.
  - Cleared by pcs_reset and on each entry to LOCKED.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, rx_sd=0, 20 bit strobes -> 4 RSCD pulses, each with RXn=SILENCE; rx_locked=0; align_state=0.
- rx_sd=1; stream 3 random bits, then J,J,J,0x1E(11110) -> HUNT aligns on the first J, CONFIRM on the second -> LOCKED. Next emits are RXn=11000, then RXn=11110 with RXn_1=11000 and RXn_2=SILENCE.
- rx_sd=1; stream J, then 10101, then J,J -> CONFIRM fails on 10101 and returns to HUNT; lock is asserted only after the later J pair; no non-SILENCE emit before then.
- Locked; drop rx_sd on the same cycle as a boundary strobe -> RSCD with RXn=SILENCE; align_state=NO_SIGNAL; rx_locked=0 next clock.
- Assert pcs_reset after 2 bits of a locked symbol -> immediately RSCD=0, all RXn*=SILENCE, state NO_SIGNAL; no pulse on release.
- RX_SYM_ERR_CNT_EN: locked, feed 00000 x3 then 01110 -> sym_err_cnt=3; relock -> 0; 300 invalid codes -> 255.

Source files
------------

// File: rtl/mod_147_rx_align.sv
// Receive symbol aligner: finds 5B boundaries by locking onto SYNC (J) codes
// and emits RXn plus a three-deep symbol history. Optional macro: RX_SYM_ERR_CNT_EN.
module mod_147_rx_align #(
  parameter logic [4:0]  SYNC_CODE       = 5'b11000,
  parameter int unsigned LOCK_SYNC_COUNT = 2
) (
  input  logic       clk,
  input  logic       pcs_reset,
  input  logic       rx_sd,
  input  logic       rx_bit,
  input  logic       rx_bit_valid,
  output logic       RSCD,
  output logic [4:0] RXn,
  output logic [4:0] RXn_1,
  output logic [4:0] RXn_2,
  output logic [4:0] RXn_3,
  output logic       rx_locked,
`ifdef RX_SYM_ERR_CNT_EN
  output logic [7:0] sym_err_cnt,
`endif
  output logic [1:0] align_state
);

  localparam logic [4:0] SILENCE = 5'b11111;
  localparam logic [2:0] LockCnt = 3'(LOCK_SYNC_COUNT);

  typedef enum logic [1:0] {
    StNoSignal = 2'd0,
    StHunt     = 2'd1,
    StConfirm  = 2'd2,
    StLocked   = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_win_hist;
  logic [2:0] r_phase;
  logic [2:0] r_sync_cnt;
  logic       r_rscd;
  logic       r_locked;
  logic [4:0] r_rxn;
  logic [4:0] r_rxn1;
  logic [4:0] r_rxn2;
  logic [4:0] r_rxn3;

  logic [4:0] w_win_next;
  logic [4:0] w_emit;
  logic [2:0] w_cnt_inc;
  logic       w_boundary;
  logic       w_win_sync;
  logic       w_enter_lock;

  always_comb begin
    w_win_next   = {r_win_hist, rx_bit};
    w_boundary   = rx_bit_valid && (r_phase == 3'd4);
    w_win_sync   = (w_win_next == SYNC_CODE);
    w_cnt_inc    = r_sync_cnt + 3'd1;
    // A falling rx_sd on a boundary still emits, but only SILENCE
    w_emit       = (r_state == StLocked && rx_sd) ? w_win_next : SILENCE;
    w_enter_lock = 1'b0;
    if (rx_sd) begin
      if (r_state == StHunt && rx_bit_valid && w_win_sync && LockCnt == 3'd1) begin
        w_enter_lock = 1'b1;
      end
      if (r_state == StConfirm && w_boundary && w_win_sync && w_cnt_inc == LockCnt) begin
        w_enter_lock = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge pcs_reset) begin
    if (pcs_reset) begin
      r_state    <= StNoSignal;
      r_win_hist <= '0;
      r_phase    <= '0;
      r_sync_cnt <= '0;
      r_rscd     <= 1'b0;
      r_locked   <= 1'b0;
      r_rxn      <= SILENCE;
      r_rxn1     <= SILENCE;
      r_rxn2     <= SILENCE;
      r_rxn3     <= SILENCE;
    end else begin
      r_rscd <= w_boundary;
      if (rx_bit_valid) begin
        r_phase <= (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
      end
      if (w_boundary) begin
        r_rxn3 <= r_rxn2;
        r_rxn2 <= r_rxn1;
        r_rxn1 <= r_rxn;
        r_rxn  <= w_emit;
      end
      if (!rx_sd) begin
        if (r_state != StNoSignal) begin
          r_state    <= StNoSignal;
          r_sync_cnt <= '0;
          r_locked   <= 1'b0;
          r_win_hist <= '0;
        end
      end else begin
        unique case (r_state)
          StNoSignal: begin
            r_state    <= StHunt;
            r_win_hist <= '0;
          end
          StHunt: begin
            if (rx_bit_valid) begin
              r_win_hist <= w_win_next[3:0];
              // Overrides the phase increment above: next bit starts a symbol
              if (w_win_sync) begin
                r_phase    <= 3'd0;
                r_sync_cnt <= 3'd1;
                r_state    <= w_enter_lock ? StLocked : StConfirm;
                r_locked   <= w_enter_lock;
              end
            end
          end
          StConfirm: begin
            if (rx_bit_valid) begin
              r_win_hist <= w_win_next[3:0];
            end
            if (w_boundary) begin
              if (!w_win_sync) begin
                r_state    <= StHunt;
                r_sync_cnt <= '0;
              end else begin
                r_sync_cnt <= w_cnt_inc;
                if (w_enter_lock) begin
                  r_state  <= StLocked;
                  r_locked <= 1'b1;
                end
              end
            end
          end
          StLocked: begin
            if (rx_bit_valid) begin
              r_win_hist <= w_win_next[3:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RX_SYM_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  function automatic logic code_valid(input logic [4:0] c);
    case (c)
      5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
      5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101,
      5'b11000, 5'b10001, 5'b01101, 5'b00111, 5'b00100, 5'b11111: code_valid = 1'b1;
      default: code_valid = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge pcs_reset) begin
    if (pcs_reset) begin
      r_err_cnt <= '0;
    end else if (w_enter_lock) begin
      r_err_cnt <= '0;
    end else if (w_boundary && r_state == StLocked && rx_sd && !code_valid(w_win_next) &&
                 r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign sym_err_cnt = r_err_cnt;
`endif

  assign RSCD        = r_rscd;
  assign RXn         = r_rxn;
  assign RXn_1       = r_rxn1;
  assign RXn_2       = r_rxn2;
  assign RXn_3       = r_rxn3;
  assign rx_locked   = r_locked;
  assign align_state = r_state;

endmodule

// File: tb/tb_mod_147_rx_align.sv
// Directed bench for mod_147_rx_align; covers the optional error counter when
// RX_SYM_ERR_CNT_EN is defined.
module tb_mod_147_rx_align;

  localparam logic [4:0] SILENCE = 5'b11111;
  localparam logic [4:0] J       = 5'b11000;

  logic       clk = 1'b0;
  logic       pcs_reset;
  logic       rx_sd;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic       RSCD;
  logic [4:0] RXn;
  logic [4:0] RXn_1;
  logic [4:0] RXn_2;
  logic [4:0] RXn_3;
  logic       rx_locked;
  logic [1:0] align_state;
`ifdef RX_SYM_ERR_CNT_EN
  logic [7:0] sym_err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int nonsil  = 0;
  int p0;
  int ns0;

  mod_147_rx_align dut (
    .clk          (clk),
    .pcs_reset    (pcs_reset),
    .rx_sd        (rx_sd),
    .rx_bit       (rx_bit),
    .rx_bit_valid (rx_bit_valid),
    .RSCD         (RSCD),
    .RXn          (RXn),
    .RXn_1        (RXn_1),
    .RXn_2        (RXn_2),
    .RXn_3        (RXn_3),
    .rx_locked    (rx_locked),
`ifdef RX_SYM_ERR_CNT_EN
    .sym_err_cnt  (sym_err_cnt),
`endif
    .align_state  (align_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (RSCD === 1'b1) begin
      pulses = pulses + 1;
      if (RXn !== SILENCE) nonsil = nonsil + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_bit       = b;
    rx_bit_valid = 1'b1;
    @(negedge clk);
    #1;
    rx_bit_valid = 1'b0;
  endtask

  task automatic send_sym(input logic [4:0] code);
    for (int i = 4; i >= 0; i--) send_bit(code[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    pcs_reset    = 1'b1;
    rx_sd        = 1'b0;
    rx_bit       = 1'b0;
    rx_bit_valid = 1'b0;
    #1;
    check("rst_rscd", 32'(RSCD), 32'd0);
    check("rst_rxn", 32'(RXn), 32'(SILENCE));
    check("rst_state", 32'(align_state), 32'd0);
    check("rst_locked", 32'(rx_locked), 32'd0);
    idle(2);
    pcs_reset = 1'b0;
    idle(1);

    // Silent line: SILENCE every five strobes
    p0  = pulses;
    ns0 = nonsil;
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(1)));
    check("nosig_pulses", 32'(pulses - p0), 32'd4);
    check("nosig_nonsil", 32'(nonsil - ns0), 32'd0);
    check("nosig_locked", 32'(rx_locked), 32'd0);
    check("nosig_state", 32'(align_state), 32'd0);

    // Three stray bits, then J J J 11110
    rx_sd = 1'b1;
    idle(1);
    check("hunt_state", 32'(align_state), 32'd1);
    ns0 = nonsil;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_sym(J);
    check("cfm_state", 32'(align_state), 32'd2);
    send_sym(J);
    check("lock_state", 32'(align_state), 32'd3);
    check("lock_flag", 32'(rx_locked), 32'd1);
    check("lock_rscd", 32'(RSCD), 32'd1);
    check("lock_j_silence", 32'(RXn), 32'(SILENCE));
    check("prelock_nonsil", 32'(nonsil - ns0), 32'd0);
    send_sym(J);
    check("emit_j", 32'(RXn), 32'(J));
    send_sym(5'b11110);
    check("emit_1e", 32'(RXn), 32'h1E);
    check("emit_1e_n1", 32'(RXn_1), 32'(J));
    check("emit_1e_n2", 32'(RXn_2), 32'(SILENCE));

    // rx_sd falls together with a boundary strobe
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_sd = 1'b0;
    send_bit(1'b1);
    check("drop_rscd", 32'(RSCD), 32'd1);
    check("drop_rxn", 32'(RXn), 32'(SILENCE));
    check("drop_rxn1", 32'(RXn_1), 32'h1E);
    check("drop_state", 32'(align_state), 32'd0);
    check("drop_locked", 32'(rx_locked), 32'd0);

    // J, 10101, J, J: failed confirm then relock
    rx_sd = 1'b1;
    idle(1);
    ns0 = nonsil;
    send_sym(J);
    check("re_cfm", 32'(align_state), 32'd2);
    send_sym(5'b10101);
    check("re_hunt", 32'(align_state), 32'd1);
    send_sym(J);
    check("re_cfm2", 32'(align_state), 32'd2);
    check("re_unlocked", 32'(rx_locked), 32'd0);
    send_sym(J);
    check("re_lock", 32'(align_state), 32'd3);
    check("re_lock_flag", 32'(rx_locked), 32'd1);
    check("re_nonsil", 32'(nonsil - ns0), 32'd0);
    send_sym(5'b01110);
    check("re_emit", 32'(RXn), 32'h0E);

    // Reset two bits into a locked symbol
    send_bit(1'b1);
    send_bit(1'b1);
    pcs_reset = 1'b1;
    #1;
    check("mrst_rscd", 32'(RSCD), 32'd0);
    check("mrst_rxn", 32'(RXn), 32'(SILENCE));
    check("mrst_rxn1", 32'(RXn_1), 32'(SILENCE));
    check("mrst_rxn2", 32'(RXn_2), 32'(SILENCE));
    check("mrst_rxn3", 32'(RXn_3), 32'(SILENCE));
    check("mrst_state", 32'(align_state), 32'd0);
    check("mrst_locked", 32'(rx_locked), 32'd0);
    idle(2);
    p0 = pulses;
    pcs_reset = 1'b0;
    idle(4);
    check("mrst_no_pulse", 32'(pulses - p0), 32'd0);

`ifdef RX_SYM_ERR_CNT_EN
    send_sym(J);
    send_sym(J);
    check("err_lock", 32'(align_state), 32'd3);
    check("err_init", 32'(sym_err_cnt), 32'd0);
    for (int i = 0; i < 3; i++) send_sym(5'b00000);
    send_sym(5'b01110);
    check("err_three", 32'(sym_err_cnt), 32'd3);
    rx_sd = 1'b0;
    idle(1);
    rx_sd = 1'b1;
    idle(1);
    send_sym(J);
    send_sym(J);
    check("err_relock", 32'(sym_err_cnt), 32'd0);
    for (int i = 0; i < 300; i++) send_sym(5'b00000);
    check("err_sat", 32'(sym_err_cnt), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
